// File: rtl/ps2_key_controller.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into one key event
// with valid/ready handoff, and derives snake direction/pause/restart.
module ps2_key_controller #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int CNT_W          = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    output logic       rx_en,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [1:0] dir,
    output logic       paused,
    output logic       restart_tick,
    output logic       overrun_tick
);

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             ext_f;
    logic             brk_f;
    logic [CNT_W-1:0] cnt;

    logic       tick;
    logic       is_e0;
    logic       is_f0;
    logic       is_ign;
    logic       fin;
    logic       fin_ext;
    logic       fin_brk;
    logic       req_vld;
    logic [1:0] req_dir;
    logic       is_space;
    logic       is_esc;

    assign rx_en = enable & (state != HOLD);
    assign tick  = rx_done_tick & enable;
    assign is_e0 = (rx_dout == 8'hE0);
    assign is_f0 = (rx_dout == 8'hF0);

    always_comb begin
        is_ign = 1'b0;
        case (rx_dout)
            8'h00, 8'hAA, 8'hEE,
            8'hFA, 8'hFE, 8'hFF: is_ign = 1'b1;
            default:             is_ign = 1'b0;
        endcase
    end

    // Housekeeping bytes are only swallowed outside a prefixed sequence.
    assign fin = tick && (state != HOLD) && !is_e0 && !is_f0
               && !((state == IDLE) && is_ign);

    assign fin_ext  = (state == PREFIX) & ext_f;
    assign fin_brk  = (state == PREFIX) & brk_f;
    assign is_space = !fin_ext && (rx_dout == 8'h29);
    assign is_esc   = !fin_ext && (rx_dout == 8'h76);

    always_comb begin
        req_vld = 1'b1;
        req_dir = 2'b00;
        case ({fin_ext, rx_dout})
            {1'b1, 8'h75}, {1'b0, 8'h1D}: req_dir = 2'b00;
            {1'b1, 8'h72}, {1'b0, 8'h1B}: req_dir = 2'b01;
            {1'b1, 8'h6B}, {1'b0, 8'h1C}: req_dir = 2'b10;
            {1'b1, 8'h74}, {1'b0, 8'h23}: req_dir = 2'b11;
            default:                      req_vld = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ext_f        <= 1'b0;
            brk_f        <= 1'b0;
            cnt          <= '0;
            key_valid    <= 1'b0;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_break    <= 1'b0;
            dir          <= 2'b11;
            paused       <= 1'b0;
            restart_tick <= 1'b0;
            overrun_tick <= 1'b0;
        end else begin
            restart_tick <= 1'b0;
            overrun_tick <= 1'b0;
            unique case (state)
                IDLE, PREFIX: begin
                    if (tick) begin
                        cnt <= '0;
                        if (is_e0) begin
                            ext_f <= 1'b1;
                            state <= PREFIX;
                        end else if (is_f0) begin
                            brk_f <= 1'b1;
                            state <= PREFIX;
                        end
                    end else if (state == PREFIX && enable) begin
                        if (cnt == TO_LAST) begin
                            cnt   <= '0;
                            ext_f <= 1'b0;
                            brk_f <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (rx_done_tick) overrun_tick <= 1'b1;
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (fin) begin
                state     <= HOLD;
                key_valid <= 1'b1;
                key_code  <= rx_dout;
                key_ext   <= fin_ext;
                key_break <= fin_brk;
                ext_f     <= 1'b0;
                brk_f     <= 1'b0;
                cnt       <= '0;
                if (!fin_brk) begin
                    // A reversal would make the snake run into itself.
                    if (req_vld && !paused && req_dir != (dir ^ 2'b01))
                        dir <= req_dir;
                    if (is_space) paused <= ~paused;
                    if (is_esc) begin
                        restart_tick <= 1'b1;
                        paused       <= 1'b0;
                        dir          <= 2'b11;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Bench for ps2_key_controller: directed steps plus random byte streams
// checked against a per-byte reference model of key sequences.
module tb_ps2_key_controller;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       rx_en;
    logic       key_ready;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [1:0] dir;
    logic       paused;
    logic       restart_tick;
    logic       overrun_tick;

    ps2_key_controller #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rx_done_tick(rx_done_tick),
        .rx_dout(rx_dout),
        .rx_en(rx_en),
        .key_ready(key_ready),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ext(key_ext),
        .key_break(key_break),
        .dir(dir),
        .paused(paused),
        .restart_tick(restart_tick),
        .overrun_tick(overrun_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    bit         m_seq, m_ext, m_brk, m_paused;
    int         m_last;
    logic [1:0] m_dir;
    bit         e_evt, e_ext, e_brk, e_rst;
    logic [7:0] e_code;
    int         opp[4] = '{1, 0, 3, 2};
    logic [7:0] pool[20] = '{8'hE0, 8'hF0, 8'hE0, 8'h1D, 8'h1B,
                             8'h1C, 8'h23, 8'h29, 8'h76, 8'h75,
                             8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFA,
                             8'h00, 8'hFF, 8'h12, 8'h5A, 8'hF0};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    function automatic void model_reset();
        m_seq = 0; m_ext = 0; m_brk = 0;
        m_dir = 2'b11; m_paused = 0;
    endfunction

    function automatic void game(logic [7:0] b, bit ext);
        int want = -1;
        if (ext) begin
            if (b == 8'h75) want = 0;
            if (b == 8'h72) want = 1;
            if (b == 8'h6B) want = 2;
            if (b == 8'h74) want = 3;
        end else begin
            if (b == 8'h1D) want = 0;
            if (b == 8'h1B) want = 1;
            if (b == 8'h1C) want = 2;
            if (b == 8'h23) want = 3;
            if (b == 8'h29) m_paused = !m_paused;
            if (b == 8'h76) begin
                e_rst = 1; m_paused = 0; m_dir = 2'b11;
            end
        end
        if (want >= 0 && !m_paused && opp[want] != int'(m_dir))
            m_dir = 2'(want);
    endfunction

    // t is the edge index at which the byte is taken.
    function automatic void model_byte(logic [7:0] b, int t);
        e_evt = 0; e_rst = 0;
        if (m_seq && (t - m_last) > T) begin
            m_seq = 0; m_ext = 0; m_brk = 0;
        end
        if (b == 8'hE0 || b == 8'hF0) begin
            if (b == 8'hE0) m_ext = 1;
            else m_brk = 1;
            m_seq = 1;
            m_last = t;
            return;
        end
        if (!m_seq && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}))
            return;
        e_evt = 1; e_code = b; e_ext = m_ext; e_brk = m_brk;
        m_seq = 0; m_ext = 0; m_brk = 0;
        if (!e_brk) game(b, e_ext);
    endfunction

    task automatic send(logic [7:0] b);
        int t = cyc;
        rx_done_tick = 1'b1;
        rx_dout = b;
        step();
        rx_done_tick = 1'b0;
        model_byte(b, t + 1);
        chk("valid", key_valid, e_evt);
        chk("rx_en", rx_en, enable & !e_evt);
        if (e_evt) begin
            chk("code", key_code, e_code);
            chk("ext", key_ext, e_ext);
            chk("brk", key_break, e_brk);
        end
        chk("dir", dir, m_dir);
        chk("paused", paused, m_paused);
        chk("restart", restart_tick, e_rst);
    endtask

    // Hold the event n cycles, optionally hitting it with a dropped byte.
    task automatic accept(int n, bit ov);
        for (int i = 0; i <= n; i++) begin
            key_ready = (i == n);
            rx_done_tick = ov && (i == 0);
            rx_dout = 8'($urandom);
            step();
            rx_done_tick = 1'b0;
            chk("overrun", overrun_tick, ov && (i == 0));
            chk("hold_valid", key_valid, i != n);
            chk("hold_rx_en", rx_en, i == n);
            chk("hold_code", key_code, e_code);
            chk("hold_dir", dir, m_dir);
            chk("hold_restart", restart_tick, 1'b0);
        end
        key_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        rx_done_tick = 1'b0;
        rx_dout = 8'h00;
        key_ready = 1'b0;
        step();
        step();
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 8'h00);
        chk("rst_ext", key_ext, 1'b0);
        chk("rst_brk", key_break, 1'b0);
        chk("rst_dir", dir, 2'b11);
        chk("rst_paused", paused, 1'b0);
        chk("rst_restart", restart_tick, 1'b0);
        chk("rst_overrun", overrun_tick, 1'b0);
        chk("rst_rx_en", rx_en, 1'b1);
        reset = 1'b0;
        model_reset();

        send(8'h1D); accept(0, 0);
        send(8'hE0); send(8'hF0); send(8'h75); accept(0, 0);
        send(8'hE0); send(8'h6B); accept(0, 0);
        send(8'hE0); send(8'h72); accept(1, 0);

        send(8'h29); accept(3, 1);
        send(8'h29); accept(0, 1);

        send(8'hF0); idle(T); send(8'h1B); accept(0, 0);
        send(8'hF0); idle(9); send(8'h1B); accept(0, 0);

        send(8'h1C); accept(0, 0);
        send(8'h29); accept(0, 0);
        send(8'h1D); accept(0, 0);
        send(8'h76); accept(0, 0);

        send(8'h5A);
        enable = 1'b0;
        step();
        chk("dis_rx_en", rx_en, 1'b0);
        chk("dis_valid", key_valid, 1'b1);
        chk("dis_code", key_code, 8'h5A);
        enable = 1'b1;
        accept(0, 0);

        send(8'hE0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk("mid_rst_valid", key_valid, 1'b0);
        chk("mid_rst_dir", dir, 2'b11);
        send(8'h23); accept(0, 0);

        repeat (400) begin
            send(pool[$urandom_range(0, 19)]);
            if (e_evt)
                accept($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 3) == 0)
                idle($urandom_range(T + 2, T + 6));
            else
                idle($urandom_range(0, T - 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
